// File: rtl/clock_ctrl_pkg.sv
// Shared types and helpers for the digital-clock mode sequencer.
// Holds the mode encoding and the counter-width helper.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'b00,
        SET_HH  = 2'b01,
        SET_MM  = 2'b10,
        RUNNING = 2'b11
    } mode_t;

    // Bits needed to hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic logic is_set_mode(input mode_t m);
        return (m == SET_HH) || (m == SET_MM);
    endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detector for one debounced button level.
// The history flop resets to 1 so a button held through reset is not seen as a press.
module button_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/clock_mode_controller.sv
// Mode sequencer for the digital clock: buttons + 1 Hz strobe -> run/edit controls.
// Optional feature: define AUTO_REPEAT_EN to auto-repeat a held increment in SET states.
module clock_mode_controller
    import clock_ctrl_pkg::*;
#(
`ifdef AUTO_REPEAT_EN
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
`endif
    parameter int TIMEOUT_SEC   = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       db_set,
    input  logic       db_increment,
    input  logic       db_start,
    input  logic       sec_tick,
    output logic       run_en,
    output logic       sel_hours,
    output logic       sel_minutes,
    output logic       inc_hours,
    output logic       inc_minutes,
    output logic       clr_seconds,
    output logic       blink,
    output logic [1:0] mode
);

    localparam int TO_W = cnt_width(TIMEOUT_SEC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_SEC - 1);

    logic rise_set;
    logic rise_inc;
    logic rise_start;

    button_edge_detect u_edge_set (
        .clock (clock),
        .reset (reset),
        .level (db_set),
        .rise  (rise_set)
    );

    button_edge_detect u_edge_inc (
        .clock (clock),
        .reset (reset),
        .level (db_increment),
        .rise  (rise_inc)
    );

    button_edge_detect u_edge_start (
        .clock (clock),
        .reset (reset),
        .level (db_start),
        .rise  (rise_start)
    );

    mode_t           state_q, state_d;
    logic [TO_W-1:0] timeout_q, timeout_d;
    logic            blink_q, blink_d;
    logic            run_en_q, sel_hours_q, sel_minutes_q;
    logic            inc_hours_q, inc_hours_d;
    logic            inc_minutes_q, inc_minutes_d;
    logic            clr_seconds_q, clr_seconds_d;
    logic            in_set;
    logic            activity;
    logic            rpt_fire;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        inc_hours_d   = 1'b0;
        inc_minutes_d = 1'b0;
        clr_seconds_d = 1'b0;
        timeout_d     = '0;
        in_set        = is_set_mode(state_q);
        activity      = in_set & (rise_start | rise_set | rise_inc | rpt_fire);

        // start outranks set, set outranks increment; losers are dropped
        if (rise_start) begin
            case (state_q)
                STOPPED: state_d = RUNNING;
                RUNNING: state_d = STOPPED;
                SET_HH, SET_MM: begin
                    state_d       = RUNNING;
                    clr_seconds_d = 1'b1;
                end
                default: state_d = STOPPED;
            endcase
        end else if (rise_set) begin
            case (state_q)
                STOPPED: state_d = SET_HH;
                SET_HH:  state_d = SET_MM;
                SET_MM:  state_d = STOPPED;
                RUNNING: state_d = SET_HH;
                default: state_d = STOPPED;
            endcase
        end else if (rise_inc || rpt_fire) begin
            inc_hours_d   = (state_q == SET_HH);
            inc_minutes_d = (state_q == SET_MM);
        end

        // Idle-second count only runs while editing with no activity this cycle.
        if (in_set && !activity) begin
            timeout_d = timeout_q;
            if (sec_tick) begin
                if (timeout_q == TO_LAST) begin
                    state_d   = STOPPED;
                    timeout_d = '0;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
        end

        if (!is_set_mode(state_d) || (state_d != state_q)) begin
            blink_d = 1'b1;
        end else if (sec_tick) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD_C = RPT_W'(REPEAT_PERIOD);

    logic             rpt_armed_q, rpt_armed_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    // rpt_cnt_q holds the number of cycles since the press or the last repeat.
    assign rpt_fire = rpt_armed_q & db_increment &
                      (rpt_cnt_q == (rpt_phase_q ? RPT_PERIOD_C : RPT_DELAY_C));

    always_comb begin
        rpt_armed_d = rpt_armed_q;
        rpt_phase_d = rpt_phase_q;
        rpt_cnt_d   = rpt_cnt_q;
        if ((state_d != state_q) || !db_increment) begin
            rpt_armed_d = 1'b0;
            rpt_phase_d = 1'b0;
            rpt_cnt_d   = '0;
        end else if (in_set && rise_inc) begin
            rpt_armed_d = 1'b1;
            rpt_phase_d = 1'b0;
            rpt_cnt_d   = RPT_W'(1);
        end else if (rpt_fire) begin
            rpt_phase_d = 1'b1;
            rpt_cnt_d   = RPT_W'(1);
        end else if (rpt_armed_q) begin
            rpt_cnt_d   = rpt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_armed_q <= 1'b0;
            rpt_phase_q <= 1'b0;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_armed_q <= rpt_armed_d;
            rpt_phase_q <= rpt_phase_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= STOPPED;
            timeout_q     <= '0;
            blink_q       <= 1'b1;
            run_en_q      <= 1'b0;
            sel_hours_q   <= 1'b0;
            sel_minutes_q <= 1'b0;
            inc_hours_q   <= 1'b0;
            inc_minutes_q <= 1'b0;
            clr_seconds_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timeout_q     <= timeout_d;
            blink_q       <= blink_d;
            run_en_q      <= (state_d == RUNNING);
            sel_hours_q   <= (state_d == SET_HH);
            sel_minutes_q <= (state_d == SET_MM);
            inc_hours_q   <= inc_hours_d;
            inc_minutes_q <= inc_minutes_d;
            clr_seconds_q <= clr_seconds_d;
        end
    end

    assign mode        = state_q;
    assign run_en      = run_en_q;
    assign sel_hours   = sel_hours_q;
    assign sel_minutes = sel_minutes_q;
    assign inc_hours   = inc_hours_q;
    assign inc_minutes = inc_minutes_q;
    assign clr_seconds = clr_seconds_q;
    assign blink       = blink_q;

endmodule
